// File: rtl/nrisk_pkg.sv
// Shared constants, FSM state type and opcode helpers for the nrisk fetch/decode path.
package nrisk_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    // Jumps are 100x and branches 111x; the low opcode bit is a variant selector.
    localparam logic [3:0] OP_CLASS_MASK = 4'b1110;
    localparam logic [3:0] OP_J          = 4'b1000;
    localparam logic [3:0] OP_BR         = 4'b1110;

    function automatic logic is_jump(input logic [3:0] op);
        return (op & OP_CLASS_MASK) == OP_J;
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op & OP_CLASS_MASK) == OP_BR;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: program-memory req/ack, instruction valid/ready and PC redirect.
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        comando;
    logic [3:0]        operando;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, comando, operando, instr_pc,
        input  mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, comando, operando, instr_pc,
        output mem_ack, mem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_prefetch_slot.sv
// One-entry holding register (word + fetch address + valid) for the prefetched instruction.
module instr_prefetch_slot #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_take,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_pc
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else begin
            if (i_take || i_flush) begin
                r_valid <= 1'b0;
            end
            if (i_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
                r_pc    <= i_pc;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: keeps the PC, reads program memory over req/ack and presents opcode/operand.
// Define INSTR_PREFETCH_EN to add a one-entry prefetch slot for back-to-back delivery.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    instr_fetch_if.master bus
);
    import nrisk_pkg::*;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [ADDR_W-1:0] r_instr_pc, w_instr_pc_next;
    logic [DATA_W-1:0] r_ir, w_ir_next;
    logic              r_mem_req, w_mem_req_next;
    logic              r_discard, w_discard_next;
    logic              w_ack, w_accept, w_take;
    logic              w_slot_valid, w_slot_valid_next;
    logic              w_slot_load, w_slot_take, w_slot_flush;
    logic [DATA_W-1:0] w_slot_data;
    logic [ADDR_W-1:0] w_slot_pc;

`ifdef INSTR_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;

    instr_prefetch_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_slot_load),
        .i_take  (w_slot_take),
        .i_flush (w_slot_flush),
        .i_data  (bus.mem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_slot_valid),
        .o_data  (w_slot_data),
        .o_pc    (w_slot_pc)
    );
`else
    localparam bit PREFETCH = 1'b0;

    logic w_unused_slot;
    assign w_slot_valid  = 1'b0;
    assign w_slot_data   = '0;
    assign w_slot_pc     = '0;
    assign w_unused_slot = ^{w_slot_load, w_slot_take, w_slot_flush};
`endif

    // An ack only counts against a request we are actually driving.
    assign w_ack    = r_mem_req && bus.mem_ack;
    assign w_accept = w_ack && !r_discard;
    assign w_take   = (r_state == VALID) && bus.instr_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_ir       <= '0;
            r_instr_pc <= '0;
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_ir       <= w_ir_next;
            r_instr_pc <= w_instr_pc_next;
            r_discard  <= w_discard_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_instr_pc_next = r_instr_pc;
        w_discard_next  = r_discard;
        w_slot_load     = 1'b0;
        w_slot_take     = 1'b0;
        w_slot_flush    = 1'b0;
        if (w_ack) begin
            w_discard_next = 1'b0;
        end
        case (r_state)
            FETCH: begin
                if (bus.redirect_valid) begin
                    w_pc_next = bus.redirect_pc;
                    if (r_mem_req && !w_ack) begin
                        w_discard_next = 1'b1;
                    end
                end else if (w_accept) begin
                    w_ir_next       = bus.mem_rdata;
                    w_instr_pc_next = r_pc;
                    w_pc_next       = r_pc + 1'b1;
                    w_state_next    = VALID;
                end
            end
            VALID: begin
                if (bus.redirect_valid) begin
                    w_pc_next    = bus.redirect_pc;
                    w_state_next = FETCH;
                    w_slot_flush = 1'b1;
                    if (r_mem_req && !w_ack) begin
                        w_discard_next = 1'b1;
                    end
                end else if (w_take) begin
                    if (w_slot_valid) begin
                        w_ir_next       = w_slot_data;
                        w_instr_pc_next = w_slot_pc;
                        w_slot_take     = 1'b1;
                    end else if (w_accept) begin
                        w_ir_next       = bus.mem_rdata;
                        w_instr_pc_next = r_pc;
                        w_pc_next       = r_pc + 1'b1;
                    end else begin
                        w_state_next = FETCH;
                    end
                end else if (w_accept) begin
                    w_slot_load = 1'b1;
                    w_pc_next   = r_pc + 1'b1;
                end
            end
            default: w_state_next = FETCH;
        endcase
        w_slot_valid_next = (w_slot_valid && !w_slot_take && !w_slot_flush) || w_slot_load;
        w_mem_req_next    = (w_state_next == FETCH) ||
                            (PREFETCH && (w_state_next == VALID) && !w_slot_valid_next);
        // A request in flight keeps its address until acked, even across a redirect.
        w_mem_addr_next   = (r_mem_req && !w_ack) ? r_mem_addr : w_pc_next;
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr_valid = (r_state == VALID);
    assign bus.comando     = r_ir[OPC_HI:OPC_LO];
    assign bus.operando    = r_ir[OPC_LO-1:0];
    assign bus.instr_pc    = r_instr_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized ready/redirect/latency
// against a stream-level model (expected next PC, memory image, handshake protocol rules).
module tb_instr_fetch;
    import nrisk_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    instr_fetch_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    instr_fetch #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

`ifdef INSTR_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:255];
    logic [7:0] exp_pc;
    int         hs_count;
    logic [7:0] hs_q [$];
    logic [7:0] req_q [$];

    bit         busy;
    int         cnt, lat, force_lat, lat_max;
    logic [7:0] hold_addr, first_addr;
    bit         want_first, got_first;

    bit         prev_valid, prev_ready, prev_redirect, prev_hs;
    logic [15:0] prev_out;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc        = 8'h00;
        busy          = 1'b0;
        cnt           = 0;
        prev_valid    = 1'b0;
        prev_ready    = 1'b0;
        prev_redirect = 1'b0;
        prev_hs       = 1'b0;
        want_first    = 1'b0;
    endtask

    // Called at a negedge: check last cycle's consequences, drive this cycle, advance one cycle.
    task automatic step(input bit rdy, input bit rdir, input logic [7:0] tgt);
        bit ack, hs;
        if (prev_redirect) begin
            check_eq("flush_drops_valid", bus.instr_valid, 1'b0);
        end else if (prev_valid && !prev_ready) begin
            check_eq("hold_valid", bus.instr_valid, 1'b1);
            check_eq("hold_outputs", {bus.comando, bus.operando, bus.instr_pc}, prev_out);
        end
`ifndef INSTR_PREFETCH_EN
        else if (prev_hs) begin
            check_eq("bubble_after_hs", bus.instr_valid, 1'b0);
        end
        if (bus.instr_valid) begin
            check_eq("no_req_while_valid", bus.mem_req, 1'b0);
        end
`endif
        // Memory responder with per-request latency.
        if (busy) begin
            check_eq("req_held", bus.mem_req, 1'b1);
            check_eq("addr_stable", bus.mem_addr, hold_addr);
        end else if (bus.mem_req) begin
            busy      = 1'b1;
            cnt       = 0;
            lat       = (force_lat >= 0) ? force_lat : int'($urandom_range(0, lat_max));
            hold_addr = bus.mem_addr;
            req_q.push_back(bus.mem_addr);
            if (want_first) begin
                first_addr = bus.mem_addr;
                want_first = 1'b0;
                got_first  = 1'b1;
            end
        end
        ack = busy && (cnt == lat);
        if (busy) begin
            if (ack) busy = 1'b0;
            else     cnt++;
        end
        bus.mem_ack        = ack;
        bus.mem_rdata      = ack ? mem[hold_addr] : 8'($urandom);
        bus.instr_ready    = rdy;
        bus.redirect_valid = rdir;
        bus.redirect_pc    = tgt;

        hs = bus.instr_valid && rdy;
        if (hs) begin
            $display("hs pc=%02h comando=%h operando=%h", bus.instr_pc, bus.comando, bus.operando);
            check_eq("instr_pc", bus.instr_pc, exp_pc);
            check_eq("instr_word", {bus.comando, bus.operando}, mem[exp_pc]);
            hs_q.push_back(bus.instr_pc);
            hs_count++;
            exp_pc = exp_pc + 8'd1;
        end
        if (rdir) begin
            exp_pc     = tgt;
            want_first = 1'b1;
            got_first  = 1'b0;
        end
        prev_valid    = bus.instr_valid;
        prev_ready    = rdy;
        prev_redirect = rdir;
        prev_hs       = hs;
        prev_out      = {bus.comando, bus.operando, bus.instr_pc};
        @(negedge clock);
    endtask

    initial begin
        bit seen;
        int n_valid, hs0;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'hA5;
        mem[8'h40] = 8'h82;
        hs_count  = 0;
        force_lat = 0;
        lat_max   = 3;
        got_first = 1'b0;
        first_addr = 8'h00;
        model_reset();

        // Reset with a stray ack present; it must be ignored.
        reset              = 1'b1;
        bus.mem_ack        = 1'b1;
        bus.mem_rdata      = 8'h3C;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        repeat (3) @(negedge clock);
        check_eq("rst_mem_req", bus.mem_req, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr, 8'h00);
        check_eq("rst_valid", bus.instr_valid, 1'b0);
        check_eq("rst_comando", bus.comando, 4'h0);
        check_eq("rst_operando", bus.operando, 4'h0);
        check_eq("rst_instr_pc", bus.instr_pc, 8'h00);
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        step(1'b1, 1'b0, 8'h00);
        check_eq("rst_ack_ignored", bus.instr_valid, 1'b0);

        // T1: first fetch from 0 with same-cycle ack.
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.mem_req) seen = 1'b1;
            else step(1'b1, 1'b0, 8'h00);
        end
        check_eq("t1_req_seen", seen, 1'b1);
        check_eq("t1_first_addr", bus.mem_addr, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check_eq("t1_min_latency", bus.instr_valid, 1'b1);
        check_eq("t1_comando", bus.comando, 4'hA);
        check_eq("t1_operando", bus.operando, 4'h5);
        check_eq("t1_instr_pc", bus.instr_pc, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check_eq("t1_req_count", (req_q.size() >= 2), 1'b1);
        check_eq("t1_next_addr", req_q[1], 8'h01);

        // T2: hold ready low for 5 cycles while an instruction is presented.
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.instr_valid) seen = 1'b1;
            else step(1'b0, 1'b0, 8'h00);
        end
        check_eq("t2_valid_seen", seen, 1'b1);
        check_eq("t2_instr_pc", bus.instr_pc, exp_pc);
        repeat (5) step(1'b0, 1'b0, 8'h00);
`ifndef INSTR_PREFETCH_EN
        check_eq("t2_pc_hold", bus.mem_addr, exp_pc + 8'd1);
`endif

        // T3: redirect to 0x40 while a slow request is in flight.
        force_lat = 3;
        for (int i = 0; i < 30 && !busy; i++) step(1'b1, 1'b0, 8'h00);
        check_eq("t3_inflight", busy, 1'b1);
        step(1'b0, 1'b1, 8'h40);
        force_lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.instr_valid) seen = 1'b1;
            else step(1'b0, 1'b0, 8'h00);
        end
        check_eq("t3_valid_seen", seen, 1'b1);
        check_eq("t3_first_req", {got_first, first_addr}, {1'b1, 8'h40});
        check_eq("t3_target_pc", bus.instr_pc, 8'h40);

        // T4: redirect coincident with the handshake of a J instruction.
        check_eq("t4_is_jump", is_jump(bus.comando), 1'b1);
        hs0 = hs_count;
        step(1'b1, 1'b1, 8'h10);
        for (int i = 0; i < 20 && !got_first; i++) step(1'b0, 1'b0, 8'h00);
        check_eq("t4_consumed_once", hs_count - hs0, 1);
        check_eq("t4_next_fetch", {got_first, first_addr}, {1'b1, 8'h10});

        // T5: PC wrap from 0xFE.
        force_lat = 0;
        step(1'b0, 1'b1, 8'hFE);
        hs_q.delete();
        for (int i = 0; i < 40 && hs_q.size() < 3; i++) step(1'b1, 1'b0, 8'h00);
        check_eq("t5_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check_eq("t5_pc0", hs_q[0], 8'hFE);
            check_eq("t5_pc1", hs_q[1], 8'hFF);
            check_eq("t5_pc2", hs_q[2], 8'h00);
        end

        // T6: streaming throughput, with a redirect mid-stream.
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.instr_valid) seen = 1'b1;
            else step(1'b1, 1'b0, 8'h00);
        end
        n_valid = 0;
        for (int i = 0; i < 20; i++) begin
            n_valid += int'(bus.instr_valid);
            step(1'b1, 1'b0, 8'h00);
        end
        check_eq("t6_stream_valid", n_valid, PF ? 20 : 10);
        step(1'b1, 1'b1, 8'h80);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.instr_valid) seen = 1'b1;
            else step(1'b1, 1'b0, 8'h00);
        end
        check_eq("t6_target_pc", bus.instr_pc, 8'h80);
        n_valid = 0;
        for (int i = 0; i < 20; i++) begin
            n_valid += int'(bus.instr_valid);
            step(1'b1, 1'b0, 8'h00);
        end
        check_eq("t6_restream_valid", n_valid, PF ? 20 : 10);

        // Randomized ready / redirect / memory latency.
        force_lat = -1;
        hs0 = hs_count;
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) != 0, ($urandom % 20) == 0, 8'($urandom));
        end
        check_eq("rand_progress", (hs_count - hs0) > 100, 1'b1);

        // Reset in the middle of traffic restarts cleanly from RESET_PC.
        force_lat = 2;
        for (int i = 0; i < 20 && !busy; i++) step(1'b1, 1'b0, 8'h00);
        reset       = 1'b1;
        bus.mem_ack = 1'b0;
        @(negedge clock);
        check_eq("midrst_req", bus.mem_req, 1'b0);
        check_eq("midrst_valid", bus.instr_valid, 1'b0);
        reset = 1'b0;
        model_reset();
        force_lat = 0;
        hs0 = hs_count;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h00);
        check_eq("midrst_restart", (hs_count - hs0) >= 3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
